// File: rtl/fifo_ctrl_pkg.sv
// Shared constants and state encoding for the byte-FIFO pointer/flag controller.
package fifo_ctrl_pkg;

  localparam int unsigned FIFO_DEPTH   = 256;
  localparam int unsigned DEF_AF_LEVEL = 240;
  localparam int unsigned DEF_AE_LEVEL = 16;

  // One-hot so empty/full are single-bit decodes of the state register.
  typedef enum logic [2:0] {
    ST_NOMINAL = 3'b001,
    ST_EMPTY   = 3'b010,
    ST_FULL    = 3'b100
  } state_t;

endpackage

// File: rtl/fifo_ctrl_if.sv
// Byte-side handshake, status and RAM control bundle between fifo_ctrl and its parent.
interface fifo_ctrl_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              push;
  logic [DATA_W-1:0] wr_data;
  logic              pop;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              flush;
  logic              clear_err;
  logic [DATA_W-1:0] ram_wdata;
  logic [ADDR_W-1:0] ram_waddr;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_raddr;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport slave (
    input  push, wr_data, pop, flush, clear_err, ram_rdata,
    output rd_data, rd_valid, ram_wdata, ram_waddr, ram_we, ram_raddr, ram_re,
           empty, full, almost_full, almost_empty, count, overflow, underflow
  );

  modport master (
    output push, wr_data, pop, flush, clear_err, ram_rdata,
    input  rd_data, rd_valid, ram_wdata, ram_waddr, ram_we, ram_raddr, ram_re,
           empty, full, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and flag controller sequencing an external RAM256x8 as a byte FIFO.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = $clog2(FIFO_DEPTH),
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned AF_LEVEL = DEF_AF_LEVEL,
  parameter int unsigned AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic        clk,
  input  logic        reset,
  fifo_ctrl_if.slave  bus
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] waddr, raddr;
  logic [ADDR_W:0]   cnt, cnt_nxt;
  logic              push_acc, pop_acc, push_rej, pop_rej;
  logic              rd_valid_q, af_q, ae_q, ovf_q, udf_q;
  logic [DATA_W-1:0] wdata, rdata;

  // Acceptance uses the registered state; flush swallows both requests.
  always_comb begin
    push_acc = bus.push & ~bus.flush & (state != ST_FULL);
    pop_acc  = bus.pop  & ~bus.flush & (state != ST_EMPTY);
    push_rej = bus.push & ~bus.flush & (state == ST_FULL);
    pop_rej  = bus.pop  & ~bus.flush & (state == ST_EMPTY);
  end

  always_comb begin
    cnt_nxt = '0;
    if (!bus.flush)
      cnt_nxt = cnt + (ADDR_W+1)'(push_acc) - (ADDR_W+1)'(pop_acc);
  end

  always_comb begin
    state_nxt = ST_NOMINAL;
    if (cnt_nxt == '0)
      state_nxt = ST_EMPTY;
    else if (cnt_nxt == DEPTH_C)
      state_nxt = ST_FULL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      waddr      <= '0;
      raddr      <= '0;
      cnt        <= '0;
      state      <= ST_EMPTY;
      rd_valid_q <= 1'b0;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      waddr      <= bus.flush ? '0 : waddr + ADDR_W'(push_acc);
      raddr      <= bus.flush ? '0 : raddr + ADDR_W'(pop_acc);
      cnt        <= cnt_nxt;
      state      <= state_nxt;
      rd_valid_q <= pop_acc;
      af_q       <= (cnt_nxt >= AF_C);
      ae_q       <= (cnt_nxt <= AE_C);
      // Set takes precedence over a clear in the same cycle.
      ovf_q      <= push_rej | (ovf_q & ~bus.clear_err);
      udf_q      <= pop_rej  | (udf_q & ~bus.clear_err);
    end
  end

  assign wdata = bus.wr_data;
  assign rdata = bus.ram_rdata;

  assign bus.ram_wdata    = wdata;
  assign bus.ram_waddr    = waddr;
  assign bus.ram_we       = push_acc;
  assign bus.ram_raddr    = raddr;
  assign bus.ram_re       = pop_acc;
  assign bus.rd_data      = rdata;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.empty        = (state == ST_EMPTY);
  assign bus.full         = (state == ST_FULL);
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.count        = cnt;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl with a behavioural registered-read RAM beside it.
module tb_fifo_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  fifo_ctrl #(.ADDR_W(8), .DATA_W(8), .AF_LEVEL(240), .AE_LEVEL(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural RAM256x8 with one-cycle registered read.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
    if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_raddr];
  end

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [7:0]  model_q [$];
  logic [7:0]  exp_q   [$];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every rd_valid must match the oldest outstanding expected byte.
  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("rd_valid_spurious", 1, 0);
      else chk("rd_data", bus.rd_data, exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input bit p, input logic [7:0] d, input bit o,
                      input bit f = 1'b0, input bit ce = 1'b0, input bit r = 1'b0);
    bit pa, oa;
    bus.push = p; bus.wr_data = d; bus.pop = o;
    bus.flush = f; bus.clear_err = ce; reset = r;
    pa = p && !f && (model_q.size() < 256);
    oa = o && !f && (model_q.size() > 0);
    @(negedge clk);
    if (!r) begin
      chk("ram_we", bus.ram_we, pa);
      chk("ram_re", bus.ram_re, oa);
    end
    if (r || f) model_q.delete();
    else begin
      if (oa) exp_q.push_back(model_q.pop_front());
      if (pa) model_q.push_back(d);
    end
    @(posedge clk); #1;
    bus.push = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0;
    bus.clear_err = 1'b0; reset = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, bus.count, 0);
    chk({tag, "_empty"}, bus.empty, 1);
    chk({tag, "_full"}, bus.full, 0);
    chk({tag, "_rd_valid"}, bus.rd_valid, 0);
    chk({tag, "_overflow"}, bus.overflow, 0);
    chk({tag, "_underflow"}, bus.underflow, 0);
    chk({tag, "_almost_empty"}, bus.almost_empty, 1);
    chk({tag, "_almost_full"}, bus.almost_full, 0);
  endtask

  initial begin
    bus.push = 1'b0; bus.wr_data = '0; bus.pop = 1'b0;
    bus.flush = 1'b0; bus.clear_err = 1'b0; reset = 1'b1;
    step(0, 8'h00, 0, 0, 0, 1);
    step(0, 8'h00, 0, 0, 0, 1);
    chk_reset_state("rst");

    // Basic three-byte round trip.
    step(1, 8'hA1, 0); step(1, 8'hA2, 0); step(1, 8'hA3, 0);
    chk("t1_count3", bus.count, 3);
    step(0, 8'h00, 1); step(0, 8'h00, 1); step(0, 8'h00, 1);
    step(0, 8'h00, 0);
    chk("t1_count0", bus.count, 0);
    chk("t1_empty", bus.empty, 1);

    // Fill to 256; almost_full must first assert at count 240.
    for (int unsigned i = 0; i < 256; i++) begin
      step(1, i[7:0], 0);
      chk("t2_almost_full", bus.almost_full, (i + 1 >= 240) ? 1 : 0);
    end
    chk("t2_full", bus.full, 1);
    chk("t2_count256", bus.count, 256);
    chk("t2_ovf_pre", bus.overflow, 0);
    step(1, 8'hEE, 0);
    chk("t2_overflow", bus.overflow, 1);
    chk("t2_count_hold", bus.count, 256);
    step(0, 8'h00, 0);
    chk("t2_ovf_sticky", bus.overflow, 1);
    step(0, 8'h00, 0, 0, 1);
    chk("t2_ovf_cleared", bus.overflow, 0);

    // Full with push+pop each cycle: first push rejected, then steady at 255.
    step(1, 8'h5C, 1);
    chk("t4_overflow", bus.overflow, 1);
    chk("t4_count255", bus.count, 255);
    chk("t4_full", bus.full, 0);
    for (int unsigned k = 1; k < 300; k++) step(1, k[7:0] ^ 8'h5C, 1);
    chk("t4_count_steady", bus.count, 255);
    chk("t4_empty", bus.empty, 0);
    chk("t4_full_steady", bus.full, 0);
    chk("t4_almost_full", bus.almost_full, 1);
    step(0, 8'h00, 0, 0, 1);
    for (int unsigned k = 0; k < 255; k++) begin
      step(0, 8'h00, 1);
      chk("t4_almost_empty", bus.almost_empty, (254 - k <= 16) ? 1 : 0);
    end
    chk("t4_drained", bus.empty, 1);

    // Underflow, including set-wins-over-clear and push+pop while empty.
    step(0, 8'h00, 1);
    chk("t3_underflow", bus.underflow, 1);
    chk("t3_count0", bus.count, 0);
    chk("t3_rd_valid", bus.rd_valid, 0);
    step(0, 8'h00, 1, 0, 1);
    chk("t3_set_wins", bus.underflow, 1);
    step(1, 8'h77, 1);
    chk("t3_count1", bus.count, 1);
    chk("t3_underflow_pp", bus.underflow, 1);
    step(0, 8'h00, 1);
    step(0, 8'h00, 0);
    chk("t3_empty", bus.empty, 1);

    // Flush with pop: contents gone, errors kept, no stale data afterwards.
    for (int unsigned i = 0; i < 10; i++) step(1, 8'hC0 + i[7:0], 0);
    chk("t5_count10", bus.count, 10);
    step(0, 8'h00, 1, 1);
    chk("t5_count0", bus.count, 0);
    chk("t5_empty", bus.empty, 1);
    chk("t5_rd_valid", bus.rd_valid, 0);
    chk("t5_underflow_kept", bus.underflow, 1);
    chk("t5_overflow_kept", bus.overflow, 0);
    step(1, 8'h5A, 0);
    step(0, 8'h00, 1);
    step(0, 8'h00, 0);

    // Reset coinciding with an accepted pop suppresses the read response.
    step(1, 8'h11, 0); step(1, 8'h22, 0);
    step(0, 8'h00, 1, 0, 0, 1);
    chk_reset_state("t6");
    step(0, 8'h00, 0);
    chk("t6_rd_valid_after", bus.rd_valid, 0);

    step(0, 8'h00, 0);
    chk("rd_valid_missing", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
